input_conditioner: RTL and testbench
====================================

// Module: input_conditioner
// PURPOSE
//  Parametrised, multi-channel input conditioner for asynchronous board inputs (switches, keys, UART modem lines).
//  Per channel: STAGES-deep synchronizer -> debounce filter -> registered rise/fall pulse detect.
//  Sits between FPGA top-level pins and the UART/bus FSM logic.
//  Supersedes the single-bit, fixed-depth synchronizer.
// PARAMETERS
//  WIDTH           4    number of independent channels
//  STAGES          2    synchronizer flop depth, legal >= 2 (elaboration $error otherwise)
//  DEBOUNCE_CYCLES 16   consecutive cycles a new level must persist before acceptance, legal >= 1 (1 = no filtering)
//  RESET_VAL       '0   WIDTH-bit reset level for sync chain and stable_out
// PORTS
//  clk         in   1      system clock, all state on posedge
//  reset       in   1      asynchronous, active-high reset
//  async_in    in   WIDTH  raw asynchronous inputs
//  sync_out    out  WIDTH  last synchronizer stage (undebounced)
//  stable_out  out  WIDTH  debounced level
//  rise_pulse  out  WIDTH  1-cycle pulse when stable_out goes 0->1
//  fall_pulse  out  WIDTH  1-cycle pulse when stable_out goes 1->0
//  any_change  out  1      OR of rise_pulse|fall_pulse
// BEHAVIOUR
//  Reset (async assert, sync-safe deassert by upstream):
//   - all sync stages = RESET_VAL; sync_out = stable_out = RESET_VAL
//   - counters = 0; rise_pulse = fall_pulse = 0; any_change = 0
//  Synchronizer:
//   - stage[0] <= async_in; stage[k] <= stage[k-1]; sync_out = stage[STAGES-1]
//   - a level applied before edge N appears on sync_out after edge N+STAGES-1
//  Debounce, per channel i, counter width $clog2(DEBOUNCE_CYCLES+1):
//   - sync_out[i] == stable_out[i]: cnt <= 0
//   - differs and cnt == DEBOUNCE_CYCLES-1: stable_out[i] <= sync_out[i]; cnt <= 0
//     (same edge: rise_pulse[i] or fall_pulse[i] <= 1)
//   - differs otherwise: cnt <= cnt+1
//   - any cycle of agreement restarts the count
//     -> glitches shorter than DEBOUNCE_CYCLES on sync_out never reach stable_out
//   - counter saturates by construction, never wraps
//  Latency: clean step on async_in before edge N -> stable_out and pulse valid after edge N+STAGES+DEBOUNCE_CYCLES-1.
//  Pulses: registered; high exactly one cycle per accepted transition; 0 on all other cycles.
//  Channels fully independent; simultaneous transitions on several channels:
//   - each produces its own pulse
//   - any_change high one cycle (combinational OR of registered pulses)
//  Reset mid-count: counter cleared, partially filtered transition discarded, no pulse emitted.
//  No handshake: outputs continuously valid after reset deassertion.
// TESTING
//  T1 reset: WIDTH=4, async_in=4'hF during reset
//     -> sync_out=stable_out=0, pulses 0
//     after release, stable_out=4'hF at edge STAGES+16-1, rise_pulse=4'hF for 1 cycle.
//  T2 clean edge: ch0 0->1 before edge 10, STAGES=2, D=16
//     -> sync_out[0]=1 after edge 11
//     stable_out[0]=1 and rise_pulse[0]=1 after edge 27 only; pulse low after edge 28.
//  T3 glitch reject: ch1 high for 15 cycles then low
//     -> stable_out[1] stays 0, no pulses
//     repeat with 16 cycles -> single rise_pulse, later single fall_pulse.
//  T4 bounce: ch2 toggles every 3 cycles x10, then holds 1
//     -> exactly one rise_pulse, 16 cycles after sync_out last settles.
//  T5 simultaneous: ch0 rise and ch3 fall on same cycle
//     -> rise_pulse=4'b0001 and fall_pulse=4'b1000 same cycle; any_change=1 for 1 cycle.
//  T6 reset mid-count: ch0 held high 10 cycles, reset pulsed, input held high
//     -> no pulse before reset; after release full STAGES+16-1 latency restarts.

Source files
------------

// File: rtl/input_conditioner.sv
// Multi-channel input conditioner for asynchronous board inputs.
// Each channel passes through a STAGES-deep synchronizer, a debounce filter
// that accepts a new level only after it has persisted DEBOUNCE_CYCLES
// consecutive cycles, and a registered rise/fall pulse detector.
module input_conditioner #(
    parameter int                WIDTH           = 4,
    parameter int                STAGES          = 2,
    parameter int                DEBOUNCE_CYCLES = 16,
    parameter logic [WIDTH-1:0]  RESET_VAL       = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out,
    output logic [WIDTH-1:0] stable_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic             any_change
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Reject illegal configurations at elaboration time.
    if (STAGES < 2) begin : g_bad_stages
        $error("input_conditioner: STAGES must be >= 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("input_conditioner: DEBOUNCE_CYCLES must be >= 1");
    end

    logic [WIDTH-1:0] stage [STAGES];
    logic [CNT_W-1:0] cnt   [WIDTH];

    // Synchronizer shift chain; the last stage is the undebounced output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < STAGES; k++) begin
                stage[k] <= RESET_VAL;
            end
        end else begin
            stage[0] <= async_in;
            for (int k = 1; k < STAGES; k++) begin
                stage[k] <= stage[k-1];
            end
        end
    end

    assign sync_out = stage[STAGES-1];

    // Per-channel debounce: count consecutive disagreeing cycles, accept the
    // new level on the last one and emit a one-cycle edge pulse on the same edge.
    // Any agreeing cycle restarts the count, so the counter never exceeds
    // DEBOUNCE_CYCLES-1 and cannot wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
            stable_out <= RESET_VAL;
            rise_pulse <= '0;
            fall_pulse <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                rise_pulse[i] <= 1'b0;
                fall_pulse[i] <= 1'b0;
                if (sync_out[i] == stable_out[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    stable_out[i] <= sync_out[i];
                    cnt[i]        <= '0;
                    rise_pulse[i] <= sync_out[i];
                    fall_pulse[i] <= ~sync_out[i];
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Summary flag over the registered pulses of all channels.
    assign any_change = |(rise_pulse | fall_pulse);

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner (WIDTH=4, STAGES=2, D=16).
// Reference model: sync_out is async_in delayed by STAGES-1 edges; a channel's
// stable level flips at an edge when the last D sync samples all differ from it.
module tb_input_conditioner;

    localparam int W = 4;
    localparam int S = 2;
    localparam int D = 16;
    localparam int LAT = S + D - 1;   // edges from input change to acceptance

    logic         clk;
    logic         reset;
    logic [W-1:0] async_in;
    logic [W-1:0] sync_out, stable_out, rise_pulse, fall_pulse;
    logic         any_change;

    int n_total = 0;
    int n_bad   = 0;

    input_conditioner #(
        .WIDTH(W), .STAGES(S), .DEBOUNCE_CYCLES(D), .RESET_VAL('0)
    ) dut (
        .clk(clk), .reset(reset), .async_in(async_in),
        .sync_out(sync_out), .stable_out(stable_out),
        .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
        .any_change(any_change)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [W-1:0] m_sync   = '0;
    logic [W-1:0] m_stable = '0;
    logic [W-1:0] m_rise   = '0;
    logic [W-1:0] m_fall   = '0;
    logic [W-1:0] aq[$];   // recent async_in samples
    logic [W-1:0] hq[$];   // last D sync_out samples seen at edges

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            aq.delete();
            hq.delete();
            m_sync = '0; m_stable = '0; m_rise = '0; m_fall = '0;
        end else begin
            hq.push_back(m_sync);
            if (hq.size() > D) void'(hq.pop_front());
            m_rise = '0;
            m_fall = '0;
            if (hq.size() == D) begin
                for (int i = 0; i < W; i++) begin
                    bit all_diff;
                    all_diff = 1'b1;
                    foreach (hq[k]) if (hq[k][i] == m_stable[i]) all_diff = 1'b0;
                    if (all_diff) begin
                        if (m_stable[i]) m_fall[i] = 1'b1;
                        else             m_rise[i] = 1'b1;
                        m_stable[i] = ~m_stable[i];
                    end
                end
            end
            aq.push_back(async_in);
            if (aq.size() == S) m_sync = aq.pop_front();
        end
    end

    wire [4*W:0] obs = {sync_out, stable_out, rise_pulse, fall_pulse, any_change};
    wire [4*W:0] exp_v = {m_sync, m_stable, m_rise, m_fall, |(m_rise | m_fall)};

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        async_in = 4'hF;
        repeat (3) tick();
        n_total++;
        if ({sync_out, stable_out, rise_pulse, fall_pulse, any_change} !== 17'd0) begin
            n_bad++;
            $display("FAIL reset_state: got %h want 0", obs);
        end
        reset = 1'b0;
        for (int e = 1; e <= LAT + 2; e++) begin
            tick();
            n_total++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL reset_model e=%0d: got %h want %h", e, obs, exp_v);
            end
            if (e == LAT) begin
                n_total++;
                if (stable_out !== 4'h0) begin
                    n_bad++;
                    $display("FAIL reset_early: stable %h want 0", stable_out);
                end
            end
            if (e == LAT + 1) begin
                n_total++;
                if (stable_out !== 4'hF || rise_pulse !== 4'hF || any_change !== 1'b1) begin
                    n_bad++;
                    $display("FAIL reset_accept: stable %h rise %h any %b want F F 1",
                             stable_out, rise_pulse, any_change);
                end
            end
            if (e == LAT + 2) begin
                n_total++;
                if (rise_pulse !== 4'h0) begin
                    n_bad++;
                    $display("FAIL reset_pulse_len: rise %h want 0", rise_pulse);
                end
            end
        end
        async_in = 4'h0;
        repeat (LAT + 4) begin
            tick();
            n_total++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL reset_settle: got %h want %h", obs, exp_v);
            end
        end
    endtask

    task automatic test_clean_edge();
        async_in = 4'b0001;
        for (int e = 1; e <= LAT + 2; e++) begin
            tick();
            n_total++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL clean_model e=%0d: got %h want %h", e, obs, exp_v);
            end
            if (e == 1 || e == 2) begin
                n_total++;
                if (sync_out[0] !== (e == 2)) begin
                    n_bad++;
                    $display("FAIL clean_sync e=%0d: got %b want %b", e, sync_out[0], e == 2);
                end
            end
            if (e == LAT) begin
                n_total++;
                if (stable_out[0] !== 1'b0 || rise_pulse[0] !== 1'b0) begin
                    n_bad++;
                    $display("FAIL clean_early: stable %b rise %b want 0 0", stable_out[0], rise_pulse[0]);
                end
            end
            if (e == LAT + 1) begin
                n_total++;
                if (stable_out[0] !== 1'b1 || rise_pulse[0] !== 1'b1) begin
                    n_bad++;
                    $display("FAIL clean_accept: stable %b rise %b want 1 1", stable_out[0], rise_pulse[0]);
                end
            end
            if (e == LAT + 2) begin
                n_total++;
                if (rise_pulse[0] !== 1'b0) begin
                    n_bad++;
                    $display("FAIL clean_pulse_len: rise %b want 0", rise_pulse[0]);
                end
            end
        end
    endtask

    task automatic test_glitch();
        int rises, falls;
        for (int len = D - 1; len <= D; len++) begin
            rises = 0;
            falls = 0;
            async_in[1] = 1'b1;
            for (int c = 0; c < len + LAT + 8; c++) begin
                if (c == len) async_in[1] = 1'b0;
                tick();
                rises += int'(rise_pulse[1]);
                falls += int'(fall_pulse[1]);
                n_total++;
                if (obs !== exp_v) begin
                    n_bad++;
                    $display("FAIL glitch_model len=%0d: got %h want %h", len, obs, exp_v);
                end
            end
            n_total++;
            if (len == D - 1 && (rises != 0 || falls != 0)) begin
                n_bad++;
                $display("FAIL glitch_reject: rises %0d falls %0d want 0 0", rises, falls);
            end else if (len == D && (rises != 1 || falls != 1)) begin
                n_bad++;
                $display("FAIL glitch_accept: rises %0d falls %0d want 1 1", rises, falls);
            end
        end
    endtask

    task automatic test_bounce();
        int rises, falls;
        rises = 0;
        falls = 0;
        for (int t = 0; t < 10; t++) begin
            async_in[2] = ~async_in[2];
            repeat (3) begin
                tick();
                rises += int'(rise_pulse[2]);
                falls += int'(fall_pulse[2]);
                n_total++;
                if (obs !== exp_v) begin
                    n_bad++;
                    $display("FAIL bounce_model: got %h want %h", obs, exp_v);
                end
            end
        end
        async_in[2] = 1'b1;
        repeat (LAT + 10) begin
            tick();
            rises += int'(rise_pulse[2]);
            falls += int'(fall_pulse[2]);
            n_total++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL bounce_model: got %h want %h", obs, exp_v);
            end
        end
        n_total++;
        if (rises != 1 || falls != 0 || stable_out[2] !== 1'b1) begin
            n_bad++;
            $display("FAIL bounce_count: rises %0d falls %0d stable %b want 1 0 1",
                     rises, falls, stable_out[2]);
        end
    endtask

    task automatic test_simultaneous();
        async_in[0] = 1'b0;
        async_in[3] = 1'b1;
        repeat (LAT + 6) begin
            tick();
            n_total++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL simul_setup: got %h want %h", obs, exp_v);
            end
        end
        async_in[0] = 1'b1;
        async_in[3] = 1'b0;
        for (int e = 1; e <= LAT + 2; e++) begin
            tick();
            n_total++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL simul_model e=%0d: got %h want %h", e, obs, exp_v);
            end
            if (e == LAT + 1) begin
                n_total++;
                if (rise_pulse !== 4'b0001 || fall_pulse !== 4'b1000 || any_change !== 1'b1) begin
                    n_bad++;
                    $display("FAIL simul_pulses: rise %b fall %b any %b want 0001 1000 1",
                             rise_pulse, fall_pulse, any_change);
                end
            end
            if (e == LAT + 2) begin
                n_total++;
                if (any_change !== 1'b0) begin
                    n_bad++;
                    $display("FAIL simul_any_len: any %b want 0", any_change);
                end
            end
        end
    endtask

    task automatic test_reset_mid_count();
        async_in = 4'h0;
        repeat (LAT + 6) tick();
        async_in[0] = 1'b1;
        repeat (10) begin
            tick();
            n_total++;
            if (rise_pulse !== 4'h0 || stable_out[0] !== 1'b0) begin
                n_bad++;
                $display("FAIL midrst_pre: rise %h stable %b want 0 0", rise_pulse, stable_out[0]);
            end
        end
        reset = 1'b1;
        @(negedge clk);
        n_total++;
        if (obs !== 17'd0) begin
            n_bad++;
            $display("FAIL midrst_in_reset: got %h want 0", obs);
        end
        reset = 1'b0;
        for (int e = 1; e <= LAT + 2; e++) begin
            tick();
            n_total++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL midrst_model e=%0d: got %h want %h", e, obs, exp_v);
            end
            if (e == LAT) begin
                n_total++;
                if (stable_out[0] !== 1'b0 || rise_pulse[0] !== 1'b0) begin
                    n_bad++;
                    $display("FAIL midrst_early: stable %b rise %b want 0 0", stable_out[0], rise_pulse[0]);
                end
            end
            if (e == LAT + 1) begin
                n_total++;
                if (stable_out[0] !== 1'b1 || rise_pulse[0] !== 1'b1) begin
                    n_bad++;
                    $display("FAIL midrst_accept: stable %b rise %b want 1 1", stable_out[0], rise_pulse[0]);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < W; i++) begin
                if ($urandom_range(11) == 0) async_in[i] = ~async_in[i];
            end
            if (c == 1000) reset = 1'b1;
            if (c == 1002) reset = 1'b0;
            tick();
            n_total++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL random c=%0d: got %h want %h", c, obs, exp_v);
            end
        end
    endtask

    initial begin
        reset    = 1'b1;
        async_in = '0;
        test_reset();
        test_clean_edge();
        test_glitch();
        test_bounce();
        test_simultaneous();
        test_reset_mid_count();
        test_random();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
